// File: rtl/pap_move_ctrl.sv
// Stepper move sequencer: walks the driver position counter to an absolute
// target one restart pulse at a time, with limit checks and a stall timeout.
module pap_move_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] target,
  input  logic       start,
  input  logic       clr_err,
  input  logic [3:0] cont_pos,
  input  logic       limSUP,
  input  logic       limINF,
  output logic [1:0] enable,
  output logic       direccion,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned TW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [3:0]    tgt, tgt_n;
  logic [3:0]    prev, prev_n;
  logic [TW-1:0] timer, timer_n;
  logic [TW-1:0] timer_inc;
  logic          dir_n;
  logic [1:0]    code_n;
  logic          lim_hit;

  assign lim_hit   = direccion ? limSUP : limINF;
  assign timer_inc = timer + 1'b1;

  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    prev_n  = prev;
    timer_n = timer;
    dir_n   = direccion;
    code_n  = err_code;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          tgt_n = target;
          if (target == cont_pos) begin
            state_n = S_DONE;
          end else begin
            dir_n   = (target > cont_pos);
            state_n = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (lim_hit) begin
          state_n = S_FAULT;
          code_n  = 2'b01;
        end else begin
          state_n = S_PULSE;
        end
      end
      S_PULSE: begin
        prev_n  = cont_pos;
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // fault fires when the post-increment count hits the limit,
        // so the fault lands TIMEOUT_CYC cycles after the pulse
        timer_n = timer_inc;
        if (cont_pos != prev) begin
          state_n = (cont_pos == tgt) ? S_DONE : S_CHECK;
        end else if (lim_hit) begin
          state_n = S_FAULT;
          code_n  = 2'b01;
        end else if (timer_inc == T_LAST) begin
          state_n = S_FAULT;
          code_n  = 2'b10;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_FAULT: begin
        if (clr_err) begin
          state_n = S_IDLE;
          code_n  = 2'b00;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tgt       <= '0;
      prev      <= '0;
      timer     <= '0;
      enable    <= 2'b00;
      direccion <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_n;
      tgt       <= tgt_n;
      prev      <= prev_n;
      timer     <= timer_n;
      enable    <= (state_n == S_PULSE) ? 2'b01 : 2'b00;
      direccion <= dir_n;
      busy      <= (state_n == S_CHECK) ||
                   (state_n == S_PULSE) ||
                   (state_n == S_WAIT);
      done      <= (state_n == S_DONE);
      error     <= (state_n == S_FAULT);
      err_code  <= code_n;
    end
  end

endmodule

// File: tb/tb_pap_move_ctrl.sv
// Directed bench for pap_move_ctrl with a simple delayed-step driver model.
module tb_pap_move_ctrl;

  localparam int DLY = 1600;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] target;
  logic       start;
  logic       clr_err;
  logic [3:0] cont_pos;
  logic       limSUP;
  logic       limINF;

  logic [1:0] enable;
  logic       direccion, busy, done, error;
  logic [1:0] err_code;

  logic [1:0] t_enable;
  logic       t_direccion, t_busy, t_done, t_error;
  logic [1:0] t_err_code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int dcnt = 0;
  bit drv_on = 1'b1;
  bit drv_dir = 1'b0;
  int pcyc[$];
  int scyc[$];

  pap_move_ctrl dut (
    .clk(clk), .rst(rst), .target(target), .start(start),
    .clr_err(clr_err), .cont_pos(cont_pos),
    .limSUP(limSUP), .limINF(limINF),
    .enable(enable), .direccion(direccion), .busy(busy),
    .done(done), .error(error), .err_code(err_code)
  );

  pap_move_ctrl #(.TIMEOUT_CYC(100)) dut_t (
    .clk(clk), .rst(rst), .target(target), .start(start),
    .clr_err(clr_err), .cont_pos(cont_pos),
    .limSUP(limSUP), .limINF(limINF),
    .enable(t_enable), .direccion(t_direccion), .busy(t_busy),
    .done(t_done), .error(t_error), .err_code(t_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (enable == 2'b01) begin
      pulses++;
      pcyc.push_back(cyc);
      if (drv_on) begin
        dcnt    = DLY;
        drv_dir = direccion;
      end
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        cont_pos = drv_dir ? cont_pos + 4'd1 : cont_pos - 4'd1;
        scyc.push_back(cyc);
      end
    end
  endtask

  task automatic clr_log();
    pulses = 0;
    pcyc.delete();
    scyc.delete();
  endtask

  task automatic wait_done(input bit exp_dir, output bit ok);
    bit dir_bad = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (busy && direccion != exp_dir) dir_bad = 1'b1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dir_held", 32'(dir_bad), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    dcnt = 0;
  endtask

  initial begin
    bit ok;
    int pc;
    rst = 1'b1; target = '0; start = 1'b0; clr_err = 1'b0;
    cont_pos = 4'd3; limSUP = 1'b0; limINF = 1'b0;

    do_reset();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_dir", 32'(direccion), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);

    // up move 3 -> 5
    clr_log();
    target = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("up_busy", 32'(busy), 32'd1);
    chk("up_dir", 32'(direccion), 32'd1);
    chk("up_en_pre", 32'(enable), 32'd0);
    tick();
    chk("up_en_pulse", 32'(enable), 32'd1);
    tick();
    chk("up_en_low", 32'(enable), 32'd0);
    wait_done(1'b1, ok);
    chk("up_done", 32'(ok), 32'd1);
    chk("up_pulses", 32'(pulses), 32'd2);
    chk("up_pos", 32'(cont_pos), 32'd5);
    if (scyc.size() == 2 && pcyc.size() == 2) begin
      chk("up_step_pulse", 32'(pcyc[1] - scyc[0]), 32'd2);
      chk("up_done_lat", 32'(cyc - scyc[1]), 32'd1);
    end else begin
      chk("up_log_size", 32'(scyc.size()), 32'd2);
    end
    chk("up_busy_done", 32'(busy), 32'd0);
    chk("up_code", 32'(err_code), 32'd0);
    tick();
    chk("up_done_1cyc", 32'(done), 32'd0);

    // down move 2 -> 0
    clr_log();
    cont_pos = 4'd2; target = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn_dir", 32'(direccion), 32'd0);
    wait_done(1'b0, ok);
    chk("dn_done", 32'(ok), 32'd1);
    chk("dn_pulses", 32'(pulses), 32'd2);
    chk("dn_pos", 32'(cont_pos), 32'd0);
    tick();
    chk("dn_busy_after", 32'(busy), 32'd0);

    // limit pre-check fault
    clr_log();
    cont_pos = 4'd7; target = 4'd9; limSUP = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("lim_check_err", 32'(error), 32'd0);
    tick();
    chk("lim_err", 32'(error), 32'd1);
    chk("lim_code", 32'(err_code), 32'd1);
    chk("lim_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lim_start_ign", 32'(error), 32'd1);
    chk("lim_pulses", 32'(pulses), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    limSUP = 1'b0;
    chk("lim_clr_err", 32'(error), 32'd0);
    chk("lim_clr_code", 32'(err_code), 32'd0);

    // target already reached
    clr_log();
    cont_pos = 4'd4; target = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("same_done", 32'(done), 32'd1);
    chk("same_busy", 32'(busy), 32'd0);
    tick();
    chk("same_done_off", 32'(done), 32'd0);
    chk("same_pulses", 32'(pulses), 32'd0);

    // start during WAIT is ignored
    clr_log();
    target = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    target = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("wait_ign_busy", 32'(busy), 32'd1);
    chk("wait_ign_dir", 32'(direccion), 32'd1);
    wait_done(1'b1, ok);
    chk("wait_ign_done", 32'(ok), 32'd1);
    chk("wait_ign_pos", 32'(cont_pos), 32'd6);
    chk("wait_ign_pulses", 32'(pulses), 32'd2);

    // timeout on the short-timeout instance
    do_reset();
    drv_on = 1'b0;
    cont_pos = 4'd4; target = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("to_pulse", 32'(t_enable), 32'd1);
    repeat (99) tick();
    chk("to_err_early", 32'(t_error), 32'd0);
    tick();
    chk("to_err", 32'(t_error), 32'd1);
    chk("to_code", 32'(t_err_code), 32'd2);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_clr_err", 32'(t_error), 32'd0);
    chk("to_clr_code", 32'(t_err_code), 32'd0);
    target = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_restart", 32'(t_busy), 32'd1);

    // reset in the middle of WAIT
    do_reset();
    drv_on = 1'b1;
    cont_pos = 4'd2; target = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mrst_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_dir", 32'(direccion), 32'd0);
    chk("mrst_en", 32'(enable), 32'd0);
    chk("mrst_code", 32'(err_code), 32'd0);
    clr_log();
    repeat (2000) tick();
    pc = pulses;
    chk("mrst_no_pulse", 32'(pc), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pap_move_ctrl.md
# pap_move_ctrl

Move sequencer for the unipolar stepper driver. Accepts an absolute target position (0–15) with a start/busy/done handshake and issues one-cycle restart pulses and a held direction to the motor driver until its position counter equals the target. Checks the SUP/INF limit switches before and during every move and raises a latched fault if progress stalls. Sits between the user/encoder front-end and the motor driver.

## Interface
- `TIMEOUT_CYC`, default 2_000_000. Maximum cycles allowed per driver position increment (≈40 ms at 50 MHz; one increment nominally takes 32 ms).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `target`  in  4  requested absolute position; sampled only on accepted `start`.
- `start`  in  1  move request; accepted only in IDLE.
- `clr_err`  in  1  clears FAULT and returns to IDLE.
- `cont_pos`  in  4  position counter from the motor driver.
- `limSUP`  in  1  upper limit switch, active-high.
- `limINF`  in  1  lower limit switch, active-high.
- `enable`  out  2  to driver; `2'b01` = restart pulse, `2'b00` otherwise.
- `direccion`  out  1  to driver; 1 = up (increment), 0 = down.
- `busy`  out  1  high from the cycle after accept until DONE or FAULT.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  high while in FAULT.
- `err_code`  out  2  `00` none, `01` limit, `10` timeout; held until `clr_err` or `rst`.

## Operation
- All outputs are registered.
- Reset values: `enable=00`, `direccion=0`, `busy=0`, `done=0`, `error=0`, `err_code=00`. Internal state: IDLE, timer=0.
- Latched registers: `tgt` (4 b), `prev` (4 b), timer (21 b).
- IDLE: `enable=00`.
  - On `start`: latch `tgt=target`.
  - If `target==cont_pos`, go to DONE.
  - Otherwise set `direccion = (target > cont_pos)` (unsigned compare) and go to CHECK.
- CHECK:
  - If `direccion=1` and `limSUP=1`, or `direccion=0` and `limINF=1`: go to FAULT with `err_code=01`.
  - Otherwise go to PULSE.
- PULSE: exactly one cycle with `enable=01`. Latch `prev=cont_pos`, clear timer, go to WAIT.
- WAIT: `enable=00`; timer increments every cycle. Priority, highest first:
  1. `cont_pos != prev`: if `cont_pos == tgt`, go to DONE; otherwise go to CHECK.
  2. Limit asserted in the move direction: go to FAULT with `err_code=01`.
  3. `timer == TIMEOUT_CYC-1`: go to FAULT with `err_code=10`.
- DONE: `done=1` for one cycle, `busy=0`, then IDLE.
- FAULT: `enable=00`, `error=1`, `busy=0`. `start` is ignored. `clr_err` returns to IDLE and clears `err_code` on the next cycle.
- `direccion` is held constant for the whole move; it changes only on accept in IDLE.
- `start` while busy or in FAULT is ignored (no queueing).
- `cont_pos` is 4-bit and wraps inside the driver. The controller never commands past a limit, so wrap is treated as ordinary inequality. Moves 15→0 or 0→15 are direct compares, not wrap.
- `rst` mid-move: immediate return to reset values. The driver finishes its current batch on its own, with no new pulse.

## Timing
- Accept cycle N (`start` high in IDLE): `busy=1` at N+1 (CHECK), `enable=01` at N+2, `enable=00` at N+3.
- Completion: driver changes `cont_pos` at cycle M; `done=1` at M+1 and `busy=0` at M+1.
- Intermediate step: `cont_pos` change at M gives CHECK at M+1 and the next `enable=01` pulse at M+2.
- Target already reached: `start` at N gives `done=1` at N+1; `busy` never rises.
- Limit fault from CHECK: `error=1` at the cycle after CHECK.
- Timeout: `error=1` exactly `TIMEOUT_CYC` cycles after the PULSE cycle.
- `clr_err` at cycle K: `error=0` and `err_code=00` at K+1; a new `start` is accepted from K+1.

## Test plan
- Up move: `cont_pos=3`, `target=5`, model driver increments 1600 cycles after each pulse -> exactly two `enable=01` one-cycle pulses, `direccion=1` throughout, `done` one cycle after `cont_pos` becomes 5, `err_code=00`.
- Down move 2→0 with `limINF=0` -> `direccion=0`, two pulses, `done` pulse, `busy` low after.
- Limit pre-check: `cont_pos=7`, `target=9`, `limSUP=1` -> no pulse, `error=1`, `err_code=01` two cycles after `start`; `clr_err` -> IDLE.
- Timeout with `TIMEOUT_CYC=100`: driver never responds -> `err_code=10` exactly 100 cycles after the pulse; then `clr_err` followed by `start` is accepted.
- Same target and ignored starts: `target==cont_pos=4` -> `done` at N+1, no pulse. `start` asserted during WAIT -> ignored, `tgt` unchanged.
- Reset mid-WAIT -> all outputs at reset values the next cycle; no further `enable` pulses.
